mem_access_unit: RTL
====================

# mem_access_unit

Data-memory access stage sitting directly downstream of the main decoder. Consumes the decoder's 2-bit `MemRead`/`Memwrite` size codes together with the ALU-computed address and the rt register value. Performs byte-lane alignment, load sign extension and misalignment checking, and drives a single-outstanding request/ready handshake to data memory. Stalls the pipeline until the access completes, faults, or times out.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: maximum REQ cycles without `mem_ready` before a bus error; must be ≥1, fits 8 bits.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `op_valid`  in  1  the current instruction in this stage is valid; held stable with all op inputs while `stall`=1.
- `MemRead`  in  2  decoder load size: 00 none, 01 byte (lb), 10 half (lh), 11 word (lw).
- `Memwrite`  in  2  decoder store size: 00 none, 01 sb, 10 sh, 11 sw.
- `addr`  in  32  byte address from the ALU.
- `wdata`  in  32  store data (rt).
- `stall`  out  1  freeze upstream stages.
- `rdata`  out  32  sign-extended load result.
- `rdata_valid`  out  1  one-cycle pulse; `rdata` is valid.
- `misaligned`  out  1  one-cycle pulse; alignment fault or illegal op.
- `bus_error`  out  1  one-cycle pulse; timeout.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  32  word address (`addr[31:2]`, low bits 00).
- `mem_be`  out  4  byte enables; bit i = byte lane i (little-endian lanes).
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_rdata`  in  32  read data, valid with `mem_ready`.
- `mem_ready`  in  1  completes the outstanding request.

## Operation
- States: IDLE, REQ, DONE.
- IDLE: an access exists when `op_valid` and (`MemRead`≠0 or `Memwrite`≠0).
  - No access: stay in IDLE, `stall`=0.
  - Illegal op (both codes ≠0), lh with `addr[0]`=1, sh with `addr[0]`=1, or lw/sw with `addr[1:0]`≠0: go to DONE with fault flagged. No memory request is issued.
  - Otherwise: register address, byte enables, write data, we and size; go to REQ.
- REQ: `mem_req`=1, all `mem_*` outputs held stable.
  - On `mem_ready`: capture `mem_rdata` for loads; go to DONE.
  - Else increment the timeout counter. When it reaches `TIMEOUT_CYCLES`, drop the request, flag bus error and go to DONE.
- DONE: pulse exactly one of `rdata_valid` (load OK), `misaligned`, or `bus_error`. A successful store pulses none of them. Return to IDLE.
- Byte enables:
  - sb: `1<<addr[1:0]`.
  - sh: 0011 (addr[1]=0) or 1100.
  - sw: 1111.
- Store data replication:
  - sb: `wdata[7:0]` replicated into all 4 lanes.
  - sh: `wdata[15:0]` replicated into both halves.
  - sw: `wdata` as-is.
- Load extraction:
  - lb: selects lane `addr[1:0]`, sign-extended from bit 7.
  - lh: selects the half chosen by `addr[1]`, sign-extended from bit 15.
  - lw: the full word.
- `stall` is combinational: 1 in IDLE while an access exists, 1 in REQ, 0 in DONE and otherwise.
- Reset in any state: next state IDLE, counter 0, `mem_req` deasserted. A late `mem_ready` arriving after reset is ignored.

## Timing
- Reset values: every output 0, `mem_addr`/`mem_wdata`/`rdata` all zeros.
- Zero-wait access: accept in cycle 0 (IDLE), `mem_req` in cycle 1, `mem_ready` in cycle 1, DONE and result pulse in cycle 2. The pipeline advances at the end of cycle 2.
- Each wait state adds one cycle.
- Fault path: accept in cycle 0, `misaligned` pulse in cycle 1. `stall` is 1 only in cycle 0.
- Timeout: `bus_error` pulses exactly `TIMEOUT_CYCLES`+1 cycles after the first REQ cycle.
- `mem_ready` while not in REQ is ignored.
- `rdata` holds its last load value until the next successful load.

## Structure
- Shared package `mips_mem_pkg`:
  - Size encodings MEM_NONE=2'b00, MEM_BYTE=2'b01, MEM_HALF=2'b10, MEM_WORD=2'b11.
  - State enum (IDLE, REQ, DONE).
  - Default timeout constant.
- One combinational sub-module, `mem_lane_align`: computes byte enables, replicated write data, the alignment check and load extract/sign-extend from size, `addr[1:0]` and data. Everything else (FSM, counter, output registers) lives in `mem_access_unit`.

## Test plan
- lw `addr`=0x0000_0010, `mem_ready` with `mem_rdata`=0xDEAD_BEEF at the first REQ cycle → `mem_be`=1111, `rdata`=0xDEAD_BEEF with `rdata_valid` in cycle 2, `stall` high for cycles 0–1.
- lb `addr`=0x13, `mem_rdata`=0x80AA_BBCC → `mem_be`=1000, `rdata`=0xFFFF_FF80. lh `addr`=0x12 on the same data → `rdata`=0xFFFF_80AA.
- sh `addr`=0x06, `wdata`=0x1234_5678 → `mem_we`=1, `mem_be`=1100, `mem_wdata`=0x5678_5678, `mem_addr`=0x04, no result pulse.
- lw `addr`=0x02 → `misaligned` pulse in cycle 1, `mem_req` never asserted. `MemRead`=11 with `Memwrite`=11 → same behaviour.
- `TIMEOUT_CYCLES`=4, `mem_ready` held low → `bus_error` 5 cycles after the first REQ cycle, then IDLE with `stall`=0.
- `reset` asserted in REQ, then `mem_ready` pulses 2 cycles later → `mem_req`=0 from the next edge, no `rdata_valid`, state IDLE.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared encodings for the data-memory access stage.
package mips_mem_pkg;

  // Decoder size codes carried on MemRead / Memwrite
  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_BYTE = 2'b01;
  localparam logic [1:0] MEM_HALF = 2'b10;
  localparam logic [1:0] MEM_WORD = 2'b11;

  // Default number of REQ cycles without mem_ready before a bus error
  localparam int unsigned DEFAULT_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } mem_state_e;

  // Outcome remembered for the DONE cycle
  typedef enum logic [1:0] {
    RES_NONE   = 2'b00,
    RES_LOAD   = 2'b01,
    RES_FAULT  = 2'b10,
    RES_BUSERR = 2'b11
  } mem_result_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: byte enables, store replication, alignment check and
// load extraction with sign extension. Purely combinational.
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  ld_size,
  input  logic [1:0]  st_size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic        is_store,
  output logic [1:0]  size,
  output logic        fault,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  input  logic [1:0]  rd_size,
  input  logic [1:0]  rd_addr_lo,
  input  logic [31:0] rd_word,
  output logic [31:0] rd_ext
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // Request side: effective size, lane enables, replicated data, fault check
  always_comb begin
    is_store  = (st_size != MEM_NONE);
    size      = is_store ? st_size : ld_size;
    fault     = ((ld_size != MEM_NONE) && (st_size != MEM_NONE)) ||
                ((size == MEM_HALF) && addr_lo[0]) ||
                ((size == MEM_WORD) && (addr_lo != 2'b00));
    be        = 4'b0000;
    wdata_rep = 32'h0;
    case (size)
      MEM_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      MEM_HALF: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
      end
      MEM_WORD: begin
        be        = 4'b1111;
        wdata_rep = wdata;
      end
      default: begin
        be        = 4'b0000;
        wdata_rep = 32'h0;
      end
    endcase
  end

  // Response side: pick the addressed lane(s) and sign-extend
  always_comb begin
    rd_byte = 8'h0;
    case (rd_addr_lo)
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    rd_half = rd_addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
    case (rd_size)
      MEM_BYTE: rd_ext = {{24{rd_byte[7]}}, rd_byte};
      MEM_HALF: rd_ext = {{16{rd_half[15]}}, rd_half};
      default:  rd_ext = rd_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access stage: accepts one load/store from the decoder, issues a
// single outstanding request to memory and stalls until it completes, faults
// or times out.
//
// Memory handshake: mem_req is high for every REQ cycle and mem_addr, mem_be,
// mem_we and mem_wdata stay constant while it is high. A transfer completes on
// the first rising edge where mem_req and mem_ready are both 1; mem_rdata is
// sampled at that edge. mem_ready outside REQ has no effect.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [1:0]  MemRead,
  input  logic [1:0]  Memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        misaligned,
  output logic        bus_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output mem_state_e  dbg_state
);

  localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

  mem_state_e  state_q, state_d;
  mem_result_e result_q, result_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  lo_q, lo_d;
  logic [31:0] rdata_q, rdata_d;

  logic        access;
  logic        al_is_store;
  logic [1:0]  al_size;
  logic        al_fault;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] ld_ext;

  mem_lane_align u_align (
    .ld_size    (MemRead),
    .st_size    (Memwrite),
    .addr_lo    (addr[1:0]),
    .wdata      (wdata),
    .is_store   (al_is_store),
    .size       (al_size),
    .fault      (al_fault),
    .be         (al_be),
    .wdata_rep  (al_wdata),
    .rd_size    (size_q),
    .rd_addr_lo (lo_q),
    .rd_word    (mem_rdata),
    .rd_ext     (ld_ext)
  );

  assign access = op_valid && ((MemRead != MEM_NONE) || (Memwrite != MEM_NONE));

  // Next-state logic, request capture, timeout counting and stall
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    size_d   = size_q;
    lo_d     = lo_q;
    rdata_d  = rdata_q;
    stall    = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          stall = 1'b1;
          if (al_fault) begin
            result_d = RES_FAULT;
            state_d  = DONE;
          end else begin
            addr_d   = {addr[31:2], 2'b00};
            be_d     = al_be;
            wdata_d  = al_wdata;
            we_d     = al_is_store;
            size_d   = al_size;
            lo_d     = addr[1:0];
            cnt_d    = 8'd0;
            result_d = RES_NONE;
            state_d  = REQ;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        if (mem_ready) begin
          if (!we_q) begin
            rdata_d  = ld_ext;
            result_d = RES_LOAD;
          end else begin
            result_d = RES_NONE;
          end
          state_d = DONE;
        end else if (cnt_q == TMO) begin
          result_d = RES_BUSERR;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= RES_NONE;
      cnt_q    <= 8'd0;
      addr_q   <= 32'h0;
      be_q     <= 4'h0;
      wdata_q  <= 32'h0;
      we_q     <= 1'b0;
      size_q   <= MEM_NONE;
      lo_q     <= 2'b00;
      rdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      size_q   <= size_d;
      lo_q     <= lo_d;
      rdata_q  <= rdata_d;
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    mem_req     = (state_q == REQ);
    mem_we      = we_q;
    mem_addr    = addr_q;
    mem_be      = be_q;
    mem_wdata   = wdata_q;
    rdata       = rdata_q;
    rdata_valid = (state_q == DONE) && (result_q == RES_LOAD);
    misaligned  = (state_q == DONE) && (result_q == RES_FAULT);
    bus_error   = (state_q == DONE) && (result_q == RES_BUSERR);
    dbg_state   = state_q;
  end

endmodule
